// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for the 1-bit ALU slice: LSB-first stepping, carry feedback, result assembly.
// Optional signed-overflow output enabled by defining ALU_SERIAL_OVF_EN.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [7:0]       alu_m,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_c,
  input  logic             alu_out,
  input  logic             alu_next
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [7:0] OP_ADD = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_result;
  logic [7:0]       r_opr;
  logic             r_cr;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic             r_cout;
  logic             r_ovf;

  logic w_op_valid;
  logic w_is_add;
  logic w_last;

  // Only a single set bit within the five defined ALU modes is accepted.
  assign w_op_valid = (op[7:5] == 3'b000) && $onehot(op[4:0]);
  assign w_is_add   = (r_opr == OP_ADD);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = w_op_valid ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_result <= '0;
      r_opr    <= '0;
      r_cr     <= 1'b0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            if (w_op_valid) begin
              r_sa  <= opa;
              r_sb  <= opb;
              r_opr <= op;
              r_cr  <= (op == OP_ADD) ? cin : 1'b0;
              r_cnt <= '0;
              r_err <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          r_sa     <= r_sa >> 1;
          r_sb     <= r_sb >> 1;
          r_result <= {alu_out, r_result[WIDTH-1:1]};
          r_cr     <= w_is_add ? alu_next : 1'b0;
          r_cnt    <= r_cnt + CW'(1);
          // r_cr is the carry into the MSB on the last step.
          if (w_last) begin
            r_cout <= w_is_add ? alu_next : 1'b0;
            r_ovf  <= w_is_add ? (r_cr ^ alu_next) : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_m = 8'h00;
    alu_a = 1'b0;
    alu_b = 1'b0;
    alu_c = 1'b0;
    if (r_state == S_SHIFT) begin
      alu_m = r_opr;
      alu_a = r_sa[0];
      alu_b = r_sb[0];
      alu_c = r_cr;
    end
  end

  assign busy   = (r_state == S_SHIFT);
  assign done   = (r_state == S_DONE);
  assign err    = r_err;
  assign result = r_result;
  assign cout   = r_cout;

`ifdef ALU_SERIAL_OVF_EN
  assign ovf = r_ovf;
`else
  logic w_ovf_unused;
  assign w_ovf_unused = r_ovf;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl with a behavioural 1-bit ALU slice model.
module tb_alu_serial_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [7:0]       op;
  logic             cin;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic [7:0]       alu_m;
  logic             alu_a;
  logic             alu_b;
  logic             alu_c;
  logic             alu_out;
  logic             alu_next;
`ifdef ALU_SERIAL_OVF_EN
  logic             ovf;
`endif

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .cin      (cin),
    .opa      (opa),
    .opb      (opb),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .cout     (cout),
    .alu_m    (alu_m),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_c    (alu_c),
    .alu_out  (alu_out),
    .alu_next (alu_next)
`ifdef ALU_SERIAL_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  // Reference 1-bit ALU slice
  always_comb begin
    alu_out  = 1'b0;
    alu_next = 1'b0;
    case (alu_m)
      8'h01: begin
        alu_out  = alu_a ^ alu_b ^ alu_c;
        alu_next = (alu_a & alu_b) | (alu_c & (alu_a ^ alu_b));
      end
      8'h02: alu_out = alu_a & alu_b;
      8'h04: alu_out = alu_a | alu_b;
      8'h08: alu_out = alu_a ^ alu_b;
      8'h10: alu_out = ~(alu_a ^ alu_b);
      default: ;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       cout;
    logic       err;
    logic       ovf;
    int         done_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   tx_id = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks idle ALU drive.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy) begin
        chk("alu_idle", {20'b0, alu_m, alu_a, alu_b, alu_c}, 32'h0);
      end else if (alu_m != 8'h01) begin
        chk("alu_c_logic", {31'b0, alu_c}, 32'h0);
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("[TB] tx%0d done cyc=%0d result=0x%0h cout=%0b err=%0b",
                   e.id, cyc, result, cout, err);
          chk("result", {24'b0, result}, {24'b0, e.res});
          chk("cout", {31'b0, cout}, {31'b0, e.cout});
          chk("err", {31'b0, err}, {31'b0, e.err});
          chk("done_cycle", cyc, e.done_cyc);
          chk("busy_at_done", {31'b0, busy}, 32'h0);
`ifdef ALU_SERIAL_OVF_EN
          chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
`endif
        end
      end
    end
  end

  // Called at a negedge; start is held for 'hold' edges, the last of which accepts.
  // Returns at the negedge of the expected done cycle.
  task automatic issue(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [7:0] er, input logic ec,
                       input logic ee, input logic eo, input int hold);
    bit   valid;
    int   t0;
    exp_t e;
    valid = (o == 8'h01) || (o == 8'h02) || (o == 8'h04) || (o == 8'h08) || (o == 8'h10);
    op    = o;
    opa   = a;
    opb   = b;
    cin   = ci;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    repeat (hold - 1) @(posedge clk);
    tx_id++;
    e.id       = tx_id;
    e.res      = er;
    e.cout     = ec;
    e.err      = ee;
    e.ovf      = eo;
    e.done_cyc = t0 + hold - 1 + (valid ? WIDTH : 0);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    opa   = ~a;
    opb   = ~b;
    op    = 8'h08;
    cin   = ~ci;
    if (valid) begin
      for (int k = 0; k < WIDTH; k++) begin
        chk("busy_shift", {31'b0, busy}, 32'h1);
        @(negedge clk);
      end
    end
    chk("busy_done", {31'b0, busy}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 8'h00;
    cin   = 1'b0;
    opa   = '0;
    opb   = '0;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_result", {24'b0, result}, 32'h0);
    chk("rst_cout", {31'b0, cout}, 32'h0);
    chk("rst_alu", {20'b0, alu_m, alu_a, alu_b, alu_c}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Add and carry behaviour
    issue(8'h01, 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b0, 1'b1, 1);
    repeat (2) @(negedge clk);
    issue(8'h01, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1);
    repeat (2) @(negedge clk);
    issue(8'h02, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1);
    repeat (2) @(negedge clk);

    // Logic ops back-to-back: start coincident with done is ignored
    issue(8'h04, 8'hA0, 8'h05, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1);
    issue(8'h08, 8'hA5, 8'h0F, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 2);
    issue(8'h10, 8'hA5, 8'h0F, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 2);
    repeat (2) @(negedge clk);

    // Rejected opcodes, then a valid add clears err
    issue(8'h03, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    repeat (2) @(negedge clk);
    issue(8'h20, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    issue(8'h00, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2);
    repeat (2) @(negedge clk);
    issue(8'h01, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1);
    repeat (2) @(negedge clk);

    // Asynchronous reset at SHIFT cycle 4 of an add
    op    = 8'h01;
    opa   = 8'h77;
    opb   = 8'h11;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_done", {31'b0, done}, 32'h0);
    chk("arst_result", {24'b0, result}, 32'h0);
    chk("arst_cout", {31'b0, cout}, 32'h0);
    chk("arst_err", {31'b0, err}, 32'h0);
    chk("arst_alu", {20'b0, alu_m, alu_a, alu_b, alu_c}, 32'h0);
`ifdef ALU_SERIAL_OVF_EN
    chk("arst_ovf", {31'b0, ovf}, 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(8'h01, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1);
    repeat (2) @(negedge clk);

    // Signed overflow corners
    issue(8'h01, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1);
    repeat (2) @(negedge clk);
    issue(8'h01, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
